serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor: accepts two WIDTH-bit operands on a start handshake and computes A − B one bit per clock, LSB first. The borrow is held in a single flip-flop between bits. The result and the final borrow are then presented on a valid/ack handshake. It is the subtract-side counterpart to the gate-level adder cells, for datapaths that trade latency for area.

---
 rtl/serial_subtractor_pkg.sv | 16 +
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/serial_subtractor_primitive_fs.sv | 24 ++
 rtl/serial_subtractor.sv | 75 +++++++
 tb/tb_serial_subtractor.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and the
// helper that sizes the bit counter.
`timescale 1ns/1ps
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bus of the serial subtractor.
`timescale 1ns/1ps
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  // start_in is taken only while ready_out=1 (a_in/b_in sampled on that edge);
  // valid_out holds diff_out/borrow_out until an edge with ack_in=1.
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             ready_out;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;
  logic             valid_out;
  logic             ack_in;

  modport master (
    output start_in, a_in, b_in, ack_in,
    input  ready_out, diff_out, borrow_out, valid_out
  );

  modport slave (
    input  start_in, a_in, b_in, ack_in,
    output ready_out, diff_out, borrow_out, valid_out
  );
endinterface

// File: rtl/serial_subtractor_primitive_fs.sv
// One-bit full subtractor from gate primitives: d = a^b^bin,
// bout = (~a & b) | (~(a^b) & bin).
`timescale 1ns/1ps
module primitive_fs (
  input  wire a_in,
  input  wire b_in,
  input  wire bin_in,
  output wire diff_out,
  output wire bout_out
);
  wire a_x_b;
  wire a_n;
  wire a_x_b_n;
  wire brw_gen;
  wire brw_prop;

  xor u_x0 (a_x_b, a_in, b_in);
  xor u_x1 (diff_out, a_x_b, bin_in);
  not u_n0 (a_n, a_in);
  and u_a0 (brw_gen, a_n, b_in);
  not u_n1 (a_x_b_n, a_x_b);
  and u_a1 (brw_prop, a_x_b_n, bin_in);
  or  u_o0 (bout_out, brw_gen, brw_prop);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B one bit per clock, LSB first, with the
// borrow carried in a single flip-flop between bits.
`timescale 1ns/1ps
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  serial_subtractor_if.slave  bus,
  output state_t              state_dbg
);
  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;
  logic             fs_d, fs_bout;
  logic             last_bit;

  primitive_fs u_fs (
    .a_in     (a_q[0]),
    .b_in     (b_q[0]),
    .bin_in   (borrow_q),
    .diff_out (fs_d),
    .bout_out (fs_bout)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_in) state_d = SHIFT;
      SHIFT:   if (last_bit)     state_d = DONE;
      DONE:    if (bus.ack_in)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start_in) begin
        a_q      <= bus.a_in;
        b_q      <= bus.b_in;
        diff_q   <= '0;
        borrow_q <= 1'b0;
        cnt_q    <= '0;
      end else if (state_q == SHIFT) begin
        // Difference bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
        diff_q   <= {fs_d, diff_q[WIDTH-1:1]};
        a_q      <= a_q >> 1;
        b_q      <= b_q >> 1;
        borrow_q <= fs_bout;
        cnt_q    <= cnt_q + CW'(1);
      end
    end
  end

  assign bus.ready_out  = (state_q == IDLE);
  assign bus.valid_out  = (state_q == DONE);
  assign bus.diff_out   = diff_q;
  assign bus.borrow_out = borrow_q;
  assign state_dbg      = state_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized scoreboard bench for serial_subtractor (WIDTH=8).
`timescale 1ns/1ps
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 8;

  logic   clk;
  logic   rst_n;
  state_t state_dbg;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];
  logic [W:0] last_exp;
  int         tests;
  int         fails;
  int unsigned accept_cyc;
  int unsigned last_ack_cyc;
  bit         b2b_pending;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned A - B modulo 2^W; borrow is A < B.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned d;
    d = (int'(a) - int'(b) + (1 << W)) % (1 << W);
    return {(a < b), d[W-1:0]};
  endfunction

  // ---------------- monitor ----------------
  logic prev_valid;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (bus.ready_out && bus.valid_out)
        check("ready_valid_exclusive", 1, 0);
      if (bus.valid_out && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("result", {bus.borrow_out, bus.diff_out}, e);
          check("latency", cyc - accept_cyc, W);
        end
      end
      prev_valid <= bus.valid_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold_start);
    int n = 0;
    while (!bus.ready_out && n < 4 * W) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.ready_out) check("ready_timeout", 0, 1);
    bus.a_in     = a;
    bus.b_in     = b;
    bus.start_in = 1'b1;
    @(posedge clk); #1;
    accept_cyc = cyc;
    last_exp   = model(a, b);
    exp_q.push_back(last_exp);
    if (b2b_pending) check("b2b_accept_gap", accept_cyc - last_ack_cyc, 1);
    b2b_pending = 1'b0;
    if (!hold_start) bus.start_in = 1'b0;
  endtask

  task automatic wait_valid(input bit scramble);
    int n = 0;
    while (!bus.valid_out && n < 4 * W) begin
      if (scramble) begin
        bus.a_in = W'($urandom);
        bus.b_in = W'($urandom);
      end
      @(posedge clk); #1; n++;
    end
    check("valid_timeout", bus.valid_out, 1);
    bus.start_in = 1'b0;
  endtask

  task automatic hold_and_ack(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", bus.valid_out, 1);
      check("hold_ready", bus.ready_out, 0);
      check("hold_result", {bus.borrow_out, bus.diff_out}, last_exp);
    end
    bus.ack_in = 1'b1;
    @(posedge clk); #1;
    bus.ack_in   = 1'b0;
    last_ack_cyc = cyc;
    b2b_pending  = 1'b1;
    check("ack_valid_low", bus.valid_out, 0);
    check("ack_ready_high", bus.ready_out, 1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    issue(a, b, 1'b0);
    wait_valid(1'b0);
    hold_and_ack(hold);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  bus.ready_out, 1);
    check({tag, "_valid"},  bus.valid_out, 0);
    check({tag, "_diff"},   bus.diff_out, 0);
    check({tag, "_borrow"}, bus.borrow_out, 0);
    check({tag, "_state"},  state_dbg, IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    tests = 0; fails = 0; cyc = 0; b2b_pending = 1'b0;
    rst_n = 1'b0;
    bus.start_in = 1'b0; bus.ack_in = 1'b0;
    bus.a_in = '0; bus.b_in = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h5A, 8'h23, 0);
    run_op(8'h10, 8'h20, 1);
    run_op(8'h00, 8'h01, 0);
    run_op(8'hA5, 8'hA5, 5);

    // operands and start toggled during SHIFT must not disturb the captured pair
    issue(8'hC3, 8'h4E, 1'b1);
    wait_valid(1'b1);
    hold_and_ack(2);

    // reset in the middle of SHIFT aborts the operation
    b2b_pending = 1'b0;
    issue(8'h77, 8'h99, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2 * W) begin
      @(posedge clk); #1;
      if (bus.valid_out) check("abort_no_valid", bus.valid_out, 0);
    end
    check("abort_idle_ready", bus.ready_out, 1);
    run_op(8'h03, 8'h01, 0);

    // back-to-back randomized operations
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = (i % 6 == 0) ? a : W'($urandom);
      run_op(a, b, $urandom_range(0, 3));
    end

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
